// File: rtl/tt6581_pkg.sv
// Shared TT6581 SPI register-port constants and the spi_host FSM state type.
package tt6581_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_WE_BIT  = 15;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_host_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator for spi_host: half-period counter, SCLK toggle, edge strobes.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick = en_i && (r_cnt == CW'(CLK_DIV - 1));

  // Strobes mark the system edge at which the registered SCLK toggles.
  assign rise_o = w_tick & ~r_sclk;
  assign fall_o = w_tick & r_sclk;
  assign sclk_o = r_sclk;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!en_i) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_host.sv
// Mode-0 SPI master issuing 16-bit {we, addr, data} frames to the TT6581 register port.
// Readback of miso_i into rdata_o is present only when SPI_HOST_READBACK_EN is defined.
module spi_host
  import tt6581_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  we_i,
  input  logic [SPI_ADDR_W-1:0] addr_i,
  input  logic [SPI_DATA_W-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [SPI_DATA_W-1:0] rdata_o,
  output logic                  sclk_o,
  output logic                  cs_o,
  output logic                  mosi_o,
  input  logic                  miso_i
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  spi_host_state_e        r_state;
  logic [CW-1:0]          r_cnt;
  logic [3:0]             r_bit;
  logic [SPI_FRAME_W-1:0] r_sr;
  logic                   r_we;
  logic                   r_ready;
  logic                   r_done;
  logic                   r_cs;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_phase_end;

  assign w_phase_end = (r_cnt == CW'(CLK_DIV - 1));

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (r_state == SHIFT),
    .sclk_o (sclk_o),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

  // MOSI is the shift register MSB; the register is zero whenever the line must idle low.
  assign mosi_o  = r_sr[SPI_WE_BIT];
  assign ready_o = r_ready;
  assign done_o  = r_done;
  assign cs_o    = r_cs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sr    <= '0;
      r_we    <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_cs    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (start_i) begin
            r_sr    <= {we_i, addr_i, (we_i ? wdata_i : {SPI_DATA_W{1'b0}})};
            r_we    <= we_i;
            r_cs    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (w_fall) begin
            if (r_bit == 4'd15) begin
              r_state <= HOLD;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_sr  <= {r_sr[SPI_FRAME_W-2:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_cs    <= 1'b1;
            r_sr    <= '0;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SPI_HOST_READBACK_EN
  logic [SPI_DATA_W-1:0] r_rx;
  logic [SPI_DATA_W-1:0] r_rdata;

  // Bits 8..15 of the frame carry the register value from the slave.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx    <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == SHIFT) && w_rise && r_bit[3]) begin
        r_rx <= {r_rx[SPI_DATA_W-2:0], miso_i};
      end
      if ((r_state == GAP) && w_phase_end && !r_we) begin
        r_rdata <= r_rx;
      end
    end
  end

  assign rdata_o = r_rdata;
`else
  logic w_unused_rb;

  assign w_unused_rb = ^{miso_i, r_we, w_rise};
  assign rdata_o     = '0;
`endif

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: register-file slave model on the wire, directed and random frames.
module tb_spi_host;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       we = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       miso = 1'b0;
  logic       ready, done, sclk, cs, mosi;
  logic [7:0] rdata;

  spi_host #(.CLK_DIV(D)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .ready_o (ready),
    .done_o  (done),
    .rdata_o (rdata),
    .sclk_o  (sclk),
    .cs_o    (cs),
    .mosi_o  (mosi),
    .miso_i  (miso)
  );

  always #10 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  // Register file seen by the slave and by the expected-value model.
  logic [7:0] regs [128];
  logic [7:0] exp_rd = 8'h00;

  // Wire monitor / slave state.
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_mosi = 1'b0;
  int          rises = 0;
  logic [15:0] word = '0;
  logic [6:0]  sl_addr = '0;
  logic [7:0]  sl_val;
  logic [15:0] fr_q[$];
  int          fr_rises_q[$];
  int          done_cnt = 0;
  int          cs_high_len = 0;
  int          last_gap = 0;
  int          mode_err = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (prev_cs && !cs) begin
      last_gap = cs_high_len;
      rises = 0;
      word = '0;
      miso = 1'b0;
    end
    if (cs) cs_high_len++;
    else cs_high_len = 0;
    if (!cs && sclk && !prev_sclk) begin
      rises++;
      word = {word[14:0], mosi};
      if (rises == 8) sl_addr = word[6:0];
    end
    if (!cs && sclk && prev_sclk && (mosi !== prev_mosi)) mode_err++;
    if (!cs && !sclk && prev_sclk && rises >= 8 && rises < 16) begin
      sl_val = regs[sl_addr];
      miso = sl_val[15 - rises];
    end
    if (!prev_cs && cs) begin
      fr_q.push_back(word);
      fr_rises_q.push_back(rises);
    end
    prev_cs = cs;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready, 1'b1);
  endtask

  // Waits for done, counting active edges since the acceptance edge; optional busy pulse.
  task automatic wait_done(input int busy_at, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40 * D) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_at > 0) begin
        if (lat == busy_at) begin
          start = 1'b1; we = 1'b1; addr = 7'h7F; wdata = 8'hFF;
        end else begin
          start = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [15:0] frame_of(input logic w, input logic [6:0] a, input logic [7:0] d);
    return {w, a, (w ? d : 8'h00)};
  endfunction

  task automatic model_apply(input logic w, input logic [6:0] a, input logic [7:0] d);
    if (w) regs[a] = d;
`ifdef SPI_HOST_READBACK_EN
    else exp_rd = regs[a];
`endif
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_word);
    logic [15:0] w;
    int r;
    check({tag, "_frame_count"}, fr_q.size(), 1);
    if (fr_q.size() > 0) begin
      w = fr_q.pop_front();
      r = fr_rises_q.pop_front();
      check({tag, "_mosi_word"}, w, exp_word);
      check({tag, "_sclk_rises"}, r, 16);
    end
    fr_q.delete();
    fr_rises_q.delete();
  endtask

  task automatic send(input string tag, input logic w, input logic [6:0] a, input logic [7:0] d,
                      input int busy_at);
    int lat;
    int dc0;
    @(negedge clk);
    wait_ready();
    dc0 = done_cnt;
    we = w; addr = a; wdata = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    we = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    check({tag, "_cs_low"}, cs, 1'b0);
    check({tag, "_busy"}, ready, 1'b0);
    wait_done(busy_at, lat);
    start = 1'b0;
    model_apply(w, a, d);
    check({tag, "_done_latency"}, lat, 35 * D);
    check({tag, "_ready_with_done"}, ready, 1'b1);
    check({tag, "_rdata"}, rdata, exp_rd);
    repeat (2) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - dc0, 1);
    check_frame(tag, frame_of(w, a, d));
  endtask

  initial begin
    int lat;
    int n;
    int dc0;
    logic        rw;
    logic [6:0]  ra;
    logic [7:0]  rd;
    for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
    regs[7'h18] = 8'h5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs", cs, 1'b1);
    check("rst_mosi", mosi, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fr_q.delete();
    fr_rises_q.delete();

    // Directed write and read, then a write that must not disturb rdata
    send("wr05", 1'b1, 7'h05, 8'hA3, 0);
    send("rd18", 1'b0, 7'h18, 8'hC3, 0);
    send("wr_after_rd", 1'b1, 7'h22, 8'h99, 0);

    // Busy request ten cycles into a frame is ignored
    send("busy", 1'b1, 7'h11, 8'h3C, 10);
    check("busy_no_extra", fr_q.size(), 0);

    // Back-to-back with start held high
    @(negedge clk);
    wait_ready();
    dc0 = done_cnt;
    we = 1'b1; addr = 7'h40; wdata = 8'h5F; start = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; addr = 7'h40; wdata = 8'hEE;
    wait_done(0, lat);
    model_apply(1'b1, 7'h40, 8'h5F);
    check("b2b_first_latency", lat, 35 * D);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_second_cs_low", cs, 1'b0);
    wait_done(0, lat);
    model_apply(1'b0, 7'h40, 8'hEE);
    check("b2b_second_latency", lat, 35 * D);
    check("b2b_rdata", rdata, exp_rd);
    check("b2b_cs_high_gap", last_gap, D + 1);
    repeat (2) @(negedge clk);
    check("b2b_done_pulses", done_cnt - dc0, 2);
    check("b2b_frame_count", fr_q.size(), 2);
    if (fr_q.size() == 2) begin
      check("b2b_frame0", fr_q[0], frame_of(1'b1, 7'h40, 8'h5F));
      check("b2b_frame1", fr_q[1], frame_of(1'b0, 7'h40, 8'h00));
      check("b2b_rises0", fr_rises_q[0], 16);
      check("b2b_rises1", fr_rises_q[1], 16);
    end
    fr_q.delete();
    fr_rises_q.delete();

    // Mid-frame reset at bit 6
    @(negedge clk);
    wait_ready();
    dc0 = done_cnt;
    we = 1'b1; addr = 7'h33; wdata = 8'h77; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(rises == 6 && sclk === 1'b1) && n < 40 * D) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach_bit6", rises, 6);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_cs", cs, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_ready", ready, 1'b1);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40 * D) @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);
    check("midrst_rdata_kept", rdata, 8'h00);
    exp_rd = 8'h00;
    fr_q.delete();
    fr_rises_q.delete();
    send("after_rst", 1'b1, 7'h33, 8'h77, 0);

    // Loopback: voice-0 frequency registers
    send("lb_wr_flo", 1'b1, 7'h00, 8'h34, 0);
    send("lb_wr_fhi", 1'b1, 7'h01, 8'h12, 0);
    send("lb_rd_flo", 1'b0, 7'h00, 8'h00, 0);
    send("lb_rd_fhi", 1'b0, 7'h01, 8'h00, 0);

    // Randomized commands against the register-file model
    for (int i = 0; i < 12; i++) begin
      rw = 1'($urandom);
      ra = 7'($urandom);
      rd = 8'($urandom);
      send($sformatf("rand%0d", i), rw, ra, rd, 0);
    end

    check("mode0_mosi_stable_high", mode_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/spi_host.md
# spi_host

SPI master that issues single-register write and read frames to the TT6581 SPI register port, for FPGA test harnesses and the on-board sequencer. It converts a one-cycle command request (write flag, 7-bit address, 8-bit data) into a 16-bit mode-0 frame on `sclk_o`, `cs_o` and `mosi_o`. For reads it captures the returned byte from `miso_i`. It sits on the host side of the link, in the same 50 MHz clock domain as the chip model.

## Interface
Parameters:
- `CLK_DIV`, default 4: system clocks per SCLK half-period. Legal range is ≥4, so the slave's clock-domain SCLK synchroniser sees stable levels.

Ports:
- `clk_i`  in  1  system clock (50 MHz)
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low
- `start_i`  in  1  command request; accepted only when `ready_o`=1
- `we_i`  in  1  1 = write frame, 0 = read frame
- `addr_i`  in  7  register address
- `wdata_i`  in  8  write data (ignored on reads)
- `ready_o`  out  1  idle, can accept a command
- `done_o`  out  1  one-cycle pulse at end of frame
- `rdata_o`  out  8  last read byte
- `sclk_o`  out  1  SPI clock, idles low
- `cs_o`  out  1  chip select, active-low, idles high
- `mosi_o`  out  1  serial data out
- `miso_i`  in  1  serial data in

## Operation
- **Frame format:** 16 bits, MSB first. The bits are packed as {`we`, `addr[6:0]`, `data[7:0]`}.
  - Write: data bits are `wdata_i`.
  - Read: host drives 0 on data bits; the slave drives the register value on `miso_i`.
- **Command capture:** on an accepted `start_i`, `we_i`, `addr_i` and `wdata_i` are latched into a 16-bit shift register. Inputs are don't-care afterwards.
- **SPI mode 0:** MOSI changes while SCLK is low. Both ends sample on the SCLK rising edge.
- **FSM states:**
  - IDLE: `ready_o`=1. Goes to SETUP on `start_i`.
  - SETUP: `cs_o`=0, `mosi_o`=bit15, lasting CLK_DIV cycles. Then SHIFT.
  - SHIFT: 16 SCLK periods, each CLK_DIV low then CLK_DIV high.
    - On each falling edge, shift left and present the next bit.
    - On each rising edge of bits 7..0, shift `miso_i` into the receive register.
    - After the 16th high half-period, SCLK returns low, then HOLD.
  - HOLD: `cs_o`=0, SCLK low, lasting CLK_DIV cycles. Then GAP.
  - GAP: `cs_o`=1, `mosi_o`=0, lasting CLK_DIV cycles.
    - Pulse `done_o`.
    - On read frames, load `rdata_o` in the same cycle.
    - Then IDLE.
- **Counters:** half-period counter, 0..CLK_DIV-1; bit counter, 0..15. Both are cleared in IDLE.
- **Ignored requests:** `start_i` while `ready_o`=0 is ignored. Requests are not queued.
- **Write frames:** `rdata_o` keeps its previous value.

## Timing
- **Reset values:** `ready_o`=1, `done_o`=0, `rdata_o`=0, `sclk_o`=0, `cs_o`=1, `mosi_o`=0. FSM is in IDLE.
- **Acceptance:** at clock edge E where `start_i`&`ready_o`. `ready_o`=0 and `cs_o`=0 from E+1.
- **First rising SCLK edge:** at E+1+2·CLK_DIV (SETUP plus the first low half).
- **Completion:** `done_o`=1 and `ready_o`=1 in cycle E+35·CLK_DIV. This covers SETUP 1, SHIFT 32, HOLD 1 and GAP 1, in half-periods.
- **Back-to-back commands:** a new `start_i` may be accepted in the `done_o` cycle. Minimum CS-high time is therefore CLK_DIV+1 cycles.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **Mid-frame reset:** `cs_o` goes high and `sclk_o` low asynchronously. The frame is abandoned and no `done_o` is produced.

## Configuration
- **`SPI_HOST_READBACK_EN` defined:** MISO sampling, the receive shift register and the `rdata_o` update are present as above.
- **Undefined:**
  - `miso_i` is unused and `rdata_o` is tied to 0.
  - Read frames still run with identical timing, so register-side read side effects are exercised.

## Structure
- **Shared package `tt6581_pkg`:**
  - `SPI_FRAME_W`=16, `SPI_ADDR_W`=7, `SPI_DATA_W`=8, `SPI_WE_BIT`=15.
  - Typedef `spi_host_state_e` with values IDLE, SETUP, SHIFT, HOLD, GAP.
- **Sub-module `spi_clk_gen`:** half-period counter plus SCLK toggle. It outputs `rise_o` and `fall_o` one-cycle strobes and is enabled only in SHIFT.
- **Top level:** the FSM and shift registers remain in `spi_host`.

## Test plan
1. **Write frame:** `start`, `we`=1, `addr`=0x05, `wdata`=0xA3 with CLK_DIV=4.
   - MOSI at rising edges is 1,0000101,10100011.
   - Exactly 16 rising edges; `done_o` is high in cycle E+140.
2. **Read frame:** MISO model returns 0x5A for `addr`=0x18.
   - MOSI is 0,0011000,00000000.
   - `rdata_o`=0x5A with `done_o`; a following write leaves `rdata_o`=0x5A.
3. **Busy request:** `start_i` pulsed at E+10 during a frame.
   - Ignored: only one frame on the wire, one `done_o`.
4. **Back-to-back:** `start_i` held high for two commands.
   - Second CS-low begins CLK_DIV+1 cycles after the first CS-high.
   - Both frames are bit-exact.
5. **Mid-frame reset:** `rst_ni` low at bit 6.
   - Immediately `cs_o`=1, `sclk_o`=0, `ready_o`=1, no `done_o`.
   - The next command produces a correct frame.
6. **Loopback against the TT6581 top:**
   - Write voice-0 `freq_lo`=0x34 and `freq_hi`=0x12, then read back 0x34/0x12.
   - Also run with `SPI_HOST_READBACK_EN` undefined: `rdata_o` stays 0.
